score_bcd_converter: RTL and testbench
======================================

// Module: score_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble) producing the 12-bit,
//  3-digit BCD word consumed by the 7-segment display driver. Sits between the game
//  score/timer counters (binary) and the display. Handshake: start in, busy/done out;
//  the last result is held stable on bcd_out between conversions.
// PARAMETERS
//  BIN_W    10   width of binary input; legal 4..13 (internal 4-digit BCD shift register)
//  MAX_VAL  999  largest value representable on 3 digits; overflow threshold
// PORTS
//  clk      in   1       system clock, all logic on posedge
//  rst_n    in   1       synchronous reset, active-low
//  start    in   1       conversion request, sampled only in IDLE
//  bin_in   in   BIN_W   binary value, captured on the edge that accepts start
//  bcd_out  out  12      {hundreds,tens,ones}, 4 bits each, each digit 0..9
//  ovf      out  1       last converted value exceeded MAX_VAL
//  busy     out  1       high while a conversion is in progress
//  done     out  1       one-cycle pulse: bcd_out/ovf just updated
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, bcd_out=12'h000, ovf=0, busy=0, done=0;
//    internal shift/BCD registers cleared. Reset mid-conversion abandons it; no done.
//  - FSM: IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE: start=1 at edge k -> capture bin_in, clear 16-bit BCD reg, cnt=0, busy=1, go SHIFT.
//    SHIFT: each edge: every BCD digit >=5 gets +3, then {bcd,bin} shifted left 1;
//      cnt++; after BIN_W shifts (edge k+BIN_W) go DONE.
//    DONE: at edge k+BIN_W+1 update bcd_out/ovf, done=1 for that cycle, busy=0, go IDLE.
//  - Latency: done high in the cycle following edge k+BIN_W+1 (11 edges after start for
//    BIN_W=10). busy high for exactly BIN_W+1 cycles.
//  - start while busy (SHIFT/DONE) ignored; no queueing. start held high: new conversion
//    accepted on the edge when done is high (FSM already IDLE), back-to-back every BIN_W+2.
//  - bin_in changes after capture have no effect on the running conversion.
//  - bcd_out/ovf change only on the DONE edge; otherwise hold last value.
//  - ovf=1 iff captured value > MAX_VAL (thousands digit nonzero); cleared by next
//    conversion whose value is <= MAX_VAL.
//  - Adjust-by-3 applied per digit as 4-bit add with no carry between digits (digit<=9 ensures).
// CONFIGURATION
//  SAT_CLAMP_EN defined: value > MAX_VAL -> bcd_out=12'h999, ovf=1.
//  SAT_CLAMP_EN undefined: value > MAX_VAL -> bcd_out = low 3 digits (value mod 1000), ovf=1.
//  Values <= MAX_VAL identical in both builds.
// TESTING
//  1 reset, then start with bin_in=0 -> done after 11 cycles, bcd_out=12'h000, ovf=0.
//  2 bin_in=255, start one cycle -> busy high 11 cycles, done pulse 1 cycle, bcd_out=12'h255.
//  3 bin_in=999 -> bcd_out=12'h999, ovf=0; then bin_in=1023 -> ovf=1, bcd_out=12'h999
//    with SAT_CLAMP_EN, 12'h023 without.
//  4 start bin_in=42, pulse start again with bin_in=7 at cycle 3 -> ignored; result 12'h042,
//    only one done pulse.
//  5 start held high, bin_in=100 then 321 -> back-to-back results 12'h100, 12'h321,
//    done pulses 12 cycles apart.
//  6 start bin_in=500, rst_n=0 at cycle 5 -> bcd_out=12'h000, busy=0, no done; next
//    conversion of 88 -> 12'h088.

Source files
------------

// File: rtl/score_bcd_converter.sv
// Binary-to-BCD converter (shift-add-3), 3-digit result {hundreds,tens,ones} for the display.
// Latency: done pulses BIN_W+1 edges after the accepting edge; busy high BIN_W+1 cycles.
// Backpressure: none; start is ignored while busy, result held on bcd_out. Option: SAT_CLAMP_EN.
module score_bcd_converter #(
  parameter int BIN_W   = 10,
  parameter int MAX_VAL = 999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [11:0]      bcd_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int            CW    = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST  = CW'(BIN_W - 1);
  localparam logic [31:0]   MAX_U = 32'(MAX_VAL);

  state_t           state, state_nx;
  logic [BIN_W-1:0] bin_sr;
  logic [BIN_W-1:0] bin_cap;
  logic [15:0]      bcd_sr;
  logic [CW-1:0]    cnt;

  logic [15:0]         bcd_adj;
  logic [16+BIN_W-1:0] shifted;
  logic [31:0]         cap_ext;
  logic                over;
  logic [11:0]         result;

  // Per-digit +3 when digit >= 5; digits never exceed 9 so no inter-digit carry is needed.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, bin_sr} << 1;
  assign cap_ext = {{(32-BIN_W){1'b0}}, bin_cap};
  assign over    = cap_ext > MAX_U;

  // Result word: in-range values pass straight through; out-of-range is clamped or wrapped.
  always_comb begin
    result = bcd_sr[11:0];
`ifdef SAT_CLAMP_EN
    if (over) result = 12'h999;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: one SHIFT cycle per input bit, then a single DONE cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (cnt == LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs; bcd_out/ovf only move on the DONE edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_sr  <= '0;
      bin_cap <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      bcd_out <= 12'h000;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            bin_cap <= bin_in;
            bcd_sr  <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          bcd_sr <= shifted[16+BIN_W-1:BIN_W];
          bin_sr <= shifted[BIN_W-1:0];
          cnt    <= cnt + 1'b1;
        end
        S_DONE: begin
          bcd_out <= result;
          ovf     <= over;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Testbench for score_bcd_converter: directed scenarios plus random values vs arithmetic model.
// Inputs driven and outputs sampled on the falling edge.
// Honours SAT_CLAMP_EN the same way as the design build.
module tb_score_bcd_converter;

  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [BW-1:0] bin_in;
  logic [11:0]   bcd_out;
  logic          ovf, busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  score_bcd_converter #(.BIN_W(BW), .MAX_VAL(999)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .bcd_out(bcd_out), .ovf(ovf), .busy(busy), .done(done)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_bcd(input int v);
    int e;
    if (v > 999) begin
`ifdef SAT_CLAMP_EN
      e = 999;
`else
      e = v % 1000;
`endif
    end else e = v;
    return {4'(e / 100), 4'((e / 10) % 10), 4'(e % 10)};
  endfunction

  // Wait (bounded) for done; returns negedges elapsed since the first negedge after acceptance.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0; busy_cycles = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Single-cycle start pulse, full latency/busy/result/ovf checks.
  task automatic convert(input int v, input string tag);
    int lat, bc;
    bin_in = BW'(v); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin_in = BW'($urandom);
    wait_done(lat, bc);
    check({tag, "_latency"}, lat, BW + 1);
    check({tag, "_busy_cycles"}, bc, BW + 1);
    check({tag, "_bcd"}, bcd_out, model_bcd(v));
    check({tag, "_ovf"}, ovf, (v > 999) ? 1 : 0);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, done, 0);
    check({tag, "_bcd_hold"}, bcd_out, model_bcd(v));
  endtask

  initial begin
    int lat, bc, dc0, gap, v;
    rst_n = 1'b0; start = 1'b0; bin_in = '0;
    repeat (2) @(negedge clk);
    check("reset_bcd", bcd_out, 12'h000);
    check("reset_ovf", ovf, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1-3: zero, mid value, boundaries
    convert(0, "zero");
    convert(255, "v255");
    convert(999, "v999");
    convert(1023, "v1023");
    convert(5, "v5_clears_ovf");

    // 4: second start while busy is ignored
    dc0 = done_cnt;
    bin_in = BW'(42); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bin_in = BW'(7); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    check("ignore_bcd", bcd_out, 12'h042);
    repeat (15) @(negedge clk);
    check("ignore_one_done", done_cnt - dc0, 1);
    check("ignore_idle", busy, 0);

    // 5: start held high, back-to-back conversions
    bin_in = BW'(100); start = 1'b1;
    @(negedge clk);
    wait_done(lat, bc);
    check("b2b_first_bcd", bcd_out, 12'h100);
    bin_in = BW'(321);
    @(negedge clk);
    wait_done(gap, bc);
    start = 1'b0;
    check("b2b_gap", gap + 1, BW + 2);
    check("b2b_second_bcd", bcd_out, 12'h321);
    repeat (2) @(negedge clk);

    // 6: reset mid-conversion abandons it
    dc0 = done_cnt;
    bin_in = BW'(500); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_bcd", bcd_out, 12'h000);
    check("midrst_busy", busy, 0);
    repeat (15) @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);
    convert(88, "after_rst");

    // Random values against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 1023));
      convert(v, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
